// File: rtl/hdlc_tx_if.sv
// HDLC transmit framer bus: Tx buffer read-strobe handshake, control strobes,
// the serial line and the transmit status bits.
//   master : upstream side (drives requests and buffer data, observes status)
//   slave  : framer side
interface hdlc_tx_if;
  logic       Tx_Enable;        // one-cycle start request
  logic       Tx_AbortFrame;    // abort request
  logic       Tx_DataAvail;     // Tx_Data holds an unread byte
  logic [7:0] Tx_Data;          // next byte from the Tx buffer
  logic       Tx_RdBuff;        // byte on Tx_Data consumed this cycle
  logic       Tx;               // serial line
  logic       Tx_ValidFrame;    // frame on the line
  logic       Tx_Done;          // frame finished pulse
  logic       Tx_AbortedTrans;  // sticky abort status

  modport master (
    output Tx_Enable, Tx_AbortFrame, Tx_DataAvail, Tx_Data,
    input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );

  modport slave (
    input  Tx_Enable, Tx_AbortFrame, Tx_DataAvail, Tx_Data,
    output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: opening flag, LSB-first data with zero insertion,
// optional CRC-16 FCS (reflected 0xA001), closing flag, abort and idle patterns.
// Ports:
//   Clk  : system clock, posedge
//   Rst  : asynchronous active-low reset
//   bus  : hdlc_tx_if.slave (buffer handshake, strobes, Tx line, status)
module hdlc_tx_framer #(
  parameter bit          FCS_EN   = 1'b1,
  parameter logic [15:0] CRC_INIT = 16'h0000
) (
  input logic     Clk,
  input logic     Rst,
  hdlc_tx_if.slave bus
);

  localparam int unsigned BIT_W  = 3;
  localparam int unsigned ONES_W = 3;
  localparam logic [7:0]  FLAG     = 8'h7E;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  typedef enum logic [2:0] {
    S_IDLE, S_START_FLAG, S_DATA, S_FCS, S_END_FLAG, S_ABORT
  } state_e;

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [15:0]        crc_q, crc_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic               fcs_hi_q, fcs_hi_d;   // sending high FCS byte
  logic               tail_q, tail_d;       // last field bit sent, one stuffed 0 pending
  logic               tx_q, tx_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic               rd_buff_c;
  logic               bit_c;
  logic               stuff_c;
  logic [15:0]        crc_next_c;
  logic [ONES_W-1:0]  ones_next_c;

  // One bit of the reflected CRC-16 update.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic [15:0] sh;
    sh = {1'b0, crc[15:1]};
    return (crc[0] ^ b) ? (sh ^ CRC_POLY) : sh;
  endfunction

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      crc_q     <= CRC_INIT;
      ones_q    <= '0;
      fcs_hi_q  <= 1'b0;
      tail_q    <= 1'b0;
      tx_q      <= 1'b1;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      ones_q    <= ones_d;
      fcs_hi_q  <= fcs_hi_d;
      tail_q    <= tail_d;
      tx_q      <= tx_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state, bit selection, stuffing and FCS.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    crc_d       = crc_q;
    ones_d      = ones_q;
    fcs_hi_d    = fcs_hi_q;
    tail_d      = 1'b0;
    tx_d        = 1'b1;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    rd_buff_c   = 1'b0;
    bit_c       = shift_q[0];
    stuff_c     = (ones_q == ONES_W'(5));
    crc_next_c  = crc_step(crc_q, shift_q[0]);
    ones_next_c = shift_q[0] ? ones_q + ONES_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        // valid_q is still high only in the first idle cycle after a closing flag
        done_d = valid_q;
        if (bus.Tx_Enable && bus.Tx_DataAvail) begin
          state_d   = S_START_FLAG;
          bit_cnt_d = '0;
          aborted_d = 1'b0;
        end
      end

      S_START_FLAG: begin
        valid_d   = 1'b1;
        tx_d      = FLAG[bit_cnt_q];
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_W'(7)) begin
          rd_buff_c = 1'b1;
          shift_d   = bus.Tx_Data;
          ones_d    = '0;
          crc_d     = CRC_INIT;
          state_d   = S_DATA;
        end
      end

      S_DATA, S_FCS: begin
        valid_d = 1'b1;
        if (stuff_c) begin
          tx_d   = 1'b0;
          ones_d = '0;
          if (tail_q) state_d = S_END_FLAG;
        end else begin
          tx_d      = bit_c;
          ones_d    = ones_next_c;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (state_q == S_DATA) crc_d = crc_next_c;
          if (bit_cnt_q == BIT_W'(7)) begin
            if (state_q == S_DATA && bus.Tx_DataAvail) begin
              rd_buff_c = 1'b1;
              shift_d   = bus.Tx_Data;
            end else if (state_q == S_DATA && FCS_EN) begin
              state_d  = S_FCS;
              fcs_hi_d = 1'b0;
              shift_d  = crc_next_c[7:0];
            end else if (state_q == S_FCS && !fcs_hi_q) begin
              fcs_hi_d = 1'b1;
              shift_d  = crc_q[15:8];
            end else if (ones_next_c == ONES_W'(5)) begin
              // field ends on a fifth 1: send its stuffed 0 before the flag
              tail_d = 1'b1;
            end else begin
              state_d = S_END_FLAG;
            end
          end
        end
      end

      S_END_FLAG: begin
        valid_d   = 1'b1;
        tx_d      = FLAG[bit_cnt_q];
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_W'(7)) state_d = S_IDLE;
      end

      S_ABORT: begin
        tx_d      = (bit_cnt_q != '0);
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_W'(7)) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything in the active frame states, including a read.
    if (bus.Tx_AbortFrame &&
        (state_q == S_START_FLAG || state_q == S_DATA || state_q == S_FCS)) begin
      state_d   = S_ABORT;
      bit_cnt_d = '0;
      rd_buff_c = 1'b0;
      aborted_d = 1'b1;
    end
  end

  // Read strobe is combinational so the byte is taken in the cycle it is acknowledged.
  assign bus.Tx_RdBuff       = rd_buff_c;
  assign bus.Tx              = tx_q;
  assign bus.Tx_ValidFrame   = valid_q;
  assign bus.Tx_Done         = done_q;
  assign bus.Tx_AbortedTrans = aborted_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Bench for hdlc_tx_framer: per-cycle recording of the line and status,
// a frame-level reference model (flags, stuffed field, CRC-16/ARC FCS) and
// one task per scenario.
module tb_hdlc_tx_framer;
  localparam logic [15:0] CRC_INIT = 16'h0000;

  logic Clk;
  logic Rst;
  hdlc_tx_if bus();

  hdlc_tx_framer #(.FCS_EN(1'b1), .CRC_INIT(CRC_INIT)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;

  logic       s_tx[$], s_val[$], s_done[$], s_rd[$], s_ab[$];
  logic [7:0] txbuf[$];
  logic [7:0] model_bytes[$];
  logic       exp_bits[$];
  int         exp_rd[$];

  // One clock: sample at negedge, then update inputs just after posedge.
  task automatic tick();
    logic rd;
    @(negedge Clk);
    s_tx.push_back(bus.Tx);
    s_val.push_back(bus.Tx_ValidFrame);
    s_done.push_back(bus.Tx_Done);
    s_rd.push_back(bus.Tx_RdBuff);
    s_ab.push_back(bus.Tx_AbortedTrans);
    rd = bus.Tx_RdBuff;
    @(posedge Clk);
    #1;
    if (rd && txbuf.size() > 0) txbuf.delete(0);
    bus.Tx_Enable     = 1'b0;
    bus.Tx_AbortFrame = 1'b0;
    bus.Tx_DataAvail  = (txbuf.size() > 0);
    bus.Tx_Data       = (txbuf.size() > 0) ? txbuf[0] : 8'h00;
  endtask

  task automatic clear_rec();
    s_tx.delete(); s_val.delete(); s_done.delete(); s_rd.delete(); s_ab.delete();
  endtask

  task automatic start_frame(output int e);
    bus.Tx_DataAvail = 1'b1;
    bus.Tx_Data      = txbuf[0];
    bus.Tx_Enable    = 1'b1;
    e = s_tx.size();
  endtask

  function automatic void push_stuffed(input logic b, inout int ones);
    exp_bits.push_back(b);
    ones = b ? ones + 1 : 0;
    if (ones == 5) begin
      exp_bits.push_back(1'b0);
      ones = 0;
    end
  endfunction

  // Expected line bits for model_bytes, and bit indices where a read strobe is due.
  function automatic void build_model();
    logic [7:0]  flag;
    logic [7:0]  by;
    logic [15:0] crc;
    int          ones;
    int          idx;
    flag = 8'h7E;
    crc  = CRC_INIT;
    ones = 0;
    exp_bits.delete();
    exp_rd.delete();
    for (int i = 0; i < 8; i++) exp_bits.push_back(flag[i]);
    exp_rd.push_back(7);
    for (int k = 0; k < model_bytes.size(); k++) begin
      by = model_bytes[k];
      for (int i = 0; i < 8; i++) begin
        crc = (crc[0] ^ by[i]) ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
        idx = exp_bits.size();
        push_stuffed(by[i], ones);
        if (i == 7 && k < model_bytes.size() - 1) exp_rd.push_back(idx);
      end
    end
    for (int i = 0; i < 16; i++) push_stuffed(crc[i], ones);
    for (int i = 0; i < 8; i++) exp_bits.push_back(flag[i]);
  endfunction

  task automatic load_random(input int n, input logic [7:0] mask, input bit ff_bias);
    logic [7:0] v;
    model_bytes.delete();
    txbuf.delete();
    for (int k = 0; k < n; k++) begin
      v = (ff_bias && $urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom) & mask;
      model_bytes.push_back(v);
      txbuf.push_back(v);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.Tx_Enable = 1'b0; bus.Tx_AbortFrame = 1'b0;
    bus.Tx_DataAvail = 1'b0; bus.Tx_Data = 8'h00;
    #1 Rst = 1'b0;
    #1;
    n_total++;
    if (bus.Tx === 1'b1 && bus.Tx_ValidFrame === 1'b0) n_pass++;
    else $display("FAIL reset_line: Tx=%b valid=%b, want 1/0", bus.Tx, bus.Tx_ValidFrame);
    n_total++;
    if (bus.Tx_Done === 1'b0 && bus.Tx_AbortedTrans === 1'b0 && bus.Tx_RdBuff === 1'b0) n_pass++;
    else $display("FAIL reset_status: done=%b aborted=%b rd=%b, want 000",
                  bus.Tx_Done, bus.Tx_AbortedTrans, bus.Tx_RdBuff);
    repeat (3) @(posedge Clk);
    @(negedge Clk) Rst = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_idle();
    int e1, e2, e3;
    clear_rec();
    repeat (32) tick();
    bus.Tx_Enable = 1'b1;       // start with empty buffer must be ignored
    tick();
    repeat (12) tick();
    e1 = 0; e2 = 0; e3 = 0;
    for (int j = 0; j < s_tx.size(); j++) begin
      if (s_tx[j] !== 1'b1) e1++;
      if (s_val[j] !== 1'b0) e2++;
      if (s_rd[j] !== 1'b0 || s_done[j] !== 1'b0) e3++;
    end
    n_total++;
    if (e1 == 0) n_pass++; else $display("FAIL idle_tx: %0d non-1 bits, want 0", e1);
    n_total++;
    if (e2 == 0) n_pass++; else $display("FAIL idle_valid: %0d high cycles, want 0", e2);
    n_total++;
    if (e3 == 0) n_pass++; else $display("FAIL idle_strobes: %0d rd/done pulses, want 0", e3);
  endtask

  task automatic test_single_byte();
    logic [7:0] lit[5];
    logic       want[$];
    int e, errs, rdn, dn;
    lit[0] = 8'h7E; lit[1] = 8'h01; lit[2] = 8'hC1; lit[3] = 8'hC0; lit[4] = 8'h7E;
    for (int k = 0; k < 5; k++) for (int i = 0; i < 8; i++) want.push_back(lit[k][i]);
    txbuf.delete(); txbuf.push_back(8'h01);
    clear_rec(); start_frame(e);
    repeat (46) tick();
    errs = 0;
    for (int j = 0; j < 40; j++) if (s_tx[e+2+j] !== want[j]) errs++;
    n_total++;
    if (errs == 0) n_pass++; else $display("FAIL single_bits: %0d wrong of 40, want 0", errs);
    rdn = 0; dn = 0;
    foreach (s_rd[j]) begin rdn += int'(s_rd[j]); dn += int'(s_done[j]); end
    n_total++;
    if (rdn == 1 && s_rd[e+8] === 1'b1) n_pass++;
    else $display("FAIL single_rd: %0d pulses (at e+8=%b), want 1 at e+8", rdn, s_rd[e+8]);
    n_total++;
    if (dn == 1 && s_done[e+42] === 1'b1) n_pass++;
    else $display("FAIL single_done: %0d pulses (at e+42=%b), want 1 at e+42", dn, s_done[e+42]);
    n_total++;
    if (s_val[e+1] === 1'b0 && s_val[e+2] === 1'b1 && s_val[e+41] === 1'b1 && s_val[e+42] === 1'b0) n_pass++;
    else $display("FAIL single_valid: edges %b%b..%b%b, want 0110",
                  s_val[e+1], s_val[e+2], s_val[e+41], s_val[e+42]);
    repeat (3) tick();
  endtask

  task automatic test_zero_insertion();
    string lit;
    int e, n, errs, run, maxrun;
    lit = "111110111110111110";
    model_bytes.delete(); txbuf.delete();
    repeat (2) begin model_bytes.push_back(8'hFF); txbuf.push_back(8'hFF); end
    build_model();
    n = exp_bits.size();
    clear_rec(); start_frame(e);
    repeat (n + 6) tick();
    errs = 0;
    for (int j = 0; j < 18; j++) if (s_tx[e+10+j] !== (lit[j] == "1")) errs++;
    n_total++;
    if (errs == 0) n_pass++; else $display("FAIL zins_field: %0d wrong of 18, want 0", errs);
    errs = 0;
    for (int j = 0; j < n; j++) if (s_tx[e+2+j] !== exp_bits[j]) errs++;
    n_total++;
    if (errs == 0) n_pass++; else $display("FAIL zins_frame: %0d wrong of %0d, want 0", errs, n);
    run = 0; maxrun = 0;
    for (int j = e + 10; j < e + 2 + n - 8; j++) begin
      run = (s_tx[j] === 1'b1) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    n_total++;
    if (maxrun <= 5) n_pass++; else $display("FAIL zins_run: longest 1-run %0d, want <=5", maxrun);
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int e, n, errs;
    int got[$];
    model_bytes.delete(); txbuf.delete();
    model_bytes.push_back(8'h55); model_bytes.push_back(8'hAA); model_bytes.push_back(8'h0F);
    txbuf = model_bytes;
    build_model();
    n = exp_bits.size();
    clear_rec(); start_frame(e);
    repeat (n + 6) tick();
    foreach (s_rd[j]) if (s_rd[j] === 1'b1) got.push_back(j);
    n_total++;
    if (got.size() == 3 && got[0] == e + 8 && got[1] == e + 16 && got[2] == e + 24) n_pass++;
    else $display("FAIL b2b_rd: %0d pulses first at %0d, want 3 at %0d,+8,+16",
                  got.size(), got.size() > 0 ? got[0] : -1, e + 8);
    errs = 0;
    for (int j = 0; j < n; j++) if (s_tx[e+2+j] !== exp_bits[j]) errs++;
    n_total++;
    if (errs == 0) n_pass++; else $display("FAIL b2b_bits: %0d wrong of %0d, want 0", errs, n);
    repeat (3) tick();
  endtask

  task automatic test_random_frames();
    int e, n, errs, first, dn, run, maxrun;
    int got[$];
    for (int f = 0; f < 6; f++) begin
      load_random($urandom_range(1, 5), 8'hFF, 1'b1);
      build_model();
      n = exp_bits.size();
      clear_rec(); start_frame(e);
      repeat (n + 6) tick();
      errs = 0; first = 0;
      for (int j = n - 1; j >= 0; j--) if (s_tx[e+2+j] !== exp_bits[j]) begin errs++; first = j; end
      n_total++;
      if (errs == 0) n_pass++;
      else $display("FAIL rnd_bits f%0d: %0d wrong, first bit %0d got %b want %b",
                    f, errs, first, s_tx[e+2+first], exp_bits[first]);
      errs = (s_val[e+1] !== 1'b0) + (s_val[e+2+n] !== 1'b0);
      for (int j = 0; j < n; j++) if (s_val[e+2+j] !== 1'b1) errs++;
      n_total++;
      if (errs == 0) n_pass++; else $display("FAIL rnd_valid f%0d: %0d bad cycles, want 0", f, errs);
      dn = 0;
      foreach (s_done[j]) dn += int'(s_done[j]);
      n_total++;
      if (dn == 1 && s_done[e+2+n] === 1'b1) n_pass++;
      else $display("FAIL rnd_done f%0d: %0d pulses, at end=%b, want 1 at %0d", f, dn, s_done[e+2+n], e + 2 + n);
      got.delete();
      foreach (s_rd[j]) if (s_rd[j] === 1'b1) got.push_back(j);
      errs = (got.size() != exp_rd.size()) ? 1 : 0;
      for (int k = 0; k < got.size() && k < exp_rd.size(); k++) if (got[k] != e + 1 + exp_rd[k]) errs++;
      n_total++;
      if (errs == 0) n_pass++;
      else $display("FAIL rnd_rd f%0d: %0d pulses, want %0d at model positions", f, got.size(), exp_rd.size());
      run = 0; maxrun = 0;
      for (int j = e + 10; j < e + 2 + n - 8; j++) begin
        run = (s_tx[j] === 1'b1) ? run + 1 : 0;
        if (run > maxrun) maxrun = run;
      end
      n_total++;
      if (maxrun <= 5) n_pass++; else $display("FAIL rnd_run f%0d: longest 1-run %0d, want <=5", f, maxrun);
      repeat (3) tick();
    end
  endtask

  task automatic test_abort();
    int e, a, n, errs, rdn, dn;
    load_random(4, 8'h77, 1'b0);     // no stuffing, so cycle count equals bit count
    build_model();
    clear_rec(); start_frame(e);
    a = e + 21;                      // 12 data bits already chosen
    repeat (21) tick();
    bus.Tx_AbortFrame = 1'b1;
    tick();
    txbuf.delete(); bus.Tx_DataAvail = 1'b0;
    repeat (20) tick();
    errs = 0;
    for (int j = 0; j < 20; j++) if (s_tx[e+2+j] !== exp_bits[j]) errs++;
    for (int k = 0; k < 18; k++) if (s_tx[a+2+k] !== (k != 0)) errs++;
    n_total++;
    if (errs == 0) n_pass++; else $display("FAIL abort_pattern: %0d wrong bits, want 0", errs);
    errs = (s_val[a+1] !== 1'b1);
    for (int j = a + 2; j < s_val.size(); j++) if (s_val[j] !== 1'b0) errs++;
    n_total++;
    if (errs == 0) n_pass++; else $display("FAIL abort_valid: %0d bad cycles, want 0", errs);
    errs = (s_ab[a] !== 1'b0);
    for (int j = a + 1; j < s_ab.size(); j++) if (s_ab[j] !== 1'b1) errs++;
    n_total++;
    if (errs == 0) n_pass++; else $display("FAIL abort_sticky: %0d bad cycles, want 0", errs);
    rdn = 0; dn = 0;
    foreach (s_rd[j]) begin rdn += int'(s_rd[j]); dn += int'(s_done[j]); end
    n_total++;
    if (rdn == 2 && dn == 0) n_pass++;
    else $display("FAIL abort_strobes: rd=%0d done=%0d, want rd=2 done=0", rdn, dn);

    // Enable with a simultaneous abort in IDLE, then an abort during the closing flag.
    load_random(1, 8'hFF, 1'b0);
    build_model();
    n = exp_bits.size();
    clear_rec(); start_frame(e);
    bus.Tx_AbortFrame = 1'b1;
    tick();
    repeat (n - 4) tick();
    bus.Tx_AbortFrame = 1'b1;
    tick();
    repeat (8) tick();
    n_total++;
    if (s_ab[e] === 1'b1 && s_ab[e+1] === 1'b0 && s_ab[e+2+n] === 1'b0) n_pass++;
    else $display("FAIL abort_clear: aborted %b,%b,%b, want 1,0,0", s_ab[e], s_ab[e+1], s_ab[e+2+n]);
    errs = 0;
    for (int j = 0; j < n; j++) if (s_tx[e+2+j] !== exp_bits[j]) errs++;
    n_total++;
    if (errs == 0 && s_done[e+2+n] === 1'b1) n_pass++;
    else $display("FAIL abort_ignored: %0d wrong bits, done=%b, want 0 and 1", errs, s_done[e+2+n]);
    repeat (3) tick();
  endtask

  task automatic test_abort_race();
    int e, a, errs, rdn, dn;
    load_random(3, 8'h77, 1'b0);
    clear_rec(); start_frame(e);
    a = e + 16;                      // 8th data bit of the first byte
    repeat (16) tick();
    bus.Tx_AbortFrame = 1'b1;
    tick();
    txbuf.delete(); bus.Tx_DataAvail = 1'b0;
    repeat (12) tick();
    rdn = 0; dn = 0;
    foreach (s_rd[j]) begin rdn += int'(s_rd[j]); dn += int'(s_done[j]); end
    n_total++;
    if (s_rd[a] === 1'b0 && rdn == 1) n_pass++;
    else $display("FAIL race_rd: rd at abort=%b total=%0d, want 0 and 1", s_rd[a], rdn);
    errs = 0;
    for (int k = 0; k < 8; k++) if (s_tx[a+2+k] !== (k != 0)) errs++;
    n_total++;
    if (errs == 0 && s_ab[a+1] === 1'b1 && dn == 0) n_pass++;
    else $display("FAIL race_abort: %0d wrong bits aborted=%b done=%0d, want 0,1,0", errs, s_ab[a+1], dn);
  endtask

  task automatic test_reset_midframe();
    int e, n, errs;
    load_random(3, 8'hFF, 1'b0);
    clear_rec(); start_frame(e);
    repeat (15) tick();
    #2 Rst = 1'b0;
    #1;
    n_total++;
    if (bus.Tx === 1'b1 && bus.Tx_ValidFrame === 1'b0 && bus.Tx_RdBuff === 1'b0 &&
        bus.Tx_Done === 1'b0 && bus.Tx_AbortedTrans === 1'b0) n_pass++;
    else $display("FAIL rst_mid: Tx=%b valid=%b rd=%b done=%b ab=%b, want 10000",
                  bus.Tx, bus.Tx_ValidFrame, bus.Tx_RdBuff, bus.Tx_Done, bus.Tx_AbortedTrans);
    @(posedge Clk);
    #1 Rst = 1'b1;
    txbuf.delete(); bus.Tx_DataAvail = 1'b0;
    clear_rec();
    repeat (12) tick();
    errs = 0;
    foreach (s_tx[j]) if (s_tx[j] !== 1'b1 || s_val[j] !== 1'b0 || s_done[j] !== 1'b0) errs++;
    n_total++;
    if (errs == 0) n_pass++; else $display("FAIL rst_quiet: %0d non-idle cycles, want 0", errs);
    load_random(2, 8'hFF, 1'b1);
    build_model();
    n = exp_bits.size();
    clear_rec(); start_frame(e);
    repeat (n + 6) tick();
    errs = 0;
    for (int j = 0; j < n; j++) if (s_tx[e+2+j] !== exp_bits[j]) errs++;
    n_total++;
    if (errs == 0 && s_done[e+2+n] === 1'b1) n_pass++;
    else $display("FAIL rst_restart: %0d wrong bits done=%b, want 0 and 1", errs, s_done[e+2+n]);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_byte();
    test_zero_insertion();
    test_back_to_back();
    test_random_frames();
    test_abort();
    test_abort_race();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
Serial HDLC transmit framer. It pulls bytes from the Tx buffer through a read-strobe handshake and shifts them out LSB-first on Tx. It also generates the opening and closing flags (0x7E), performs zero insertion, appends a 16-bit FCS, and produces the abort and idle patterns. It is the transmit counterpart of the Rx deframer and drives the Tx-side status bits of the control register.

Parameters:
- FCS_EN, 1: when 1, append the 2-byte FCS after data; when 0, go straight from data to the closing flag.
- CRC_INIT, 16'h0000: initial FCS register value, loaded at each frame start.

Ports:
- Clk  in  1  system clock, all logic on posedge
- Rst  in  1  asynchronous, active-low reset
- Tx_Enable  in  1  one-cycle start request, honoured only in IDLE
- Tx_AbortFrame  in  1  abort request
- Tx_DataAvail  in  1  Tx_Data holds an unread byte
- Tx_Data  in  8  next byte from the Tx buffer
- Tx_RdBuff  out  1  one-cycle pulse; the byte on Tx_Data is consumed this cycle
- Tx  out  1  serial line, registered
- Tx_ValidFrame  out  1  high while a frame (flags, data, FCS) is on Tx
- Tx_Done  out  1  one-cycle pulse after the last closing-flag bit
- Tx_AbortedTrans  out  1  sticky; set when an abort is accepted

Behaviour:
- Reset:
  - State IDLE.
  - Tx=1, Tx_ValidFrame=0, Tx_Done=0, Tx_AbortedTrans=0, Tx_RdBuff=0.
  - FCS register=CRC_INIT; ones counter=0.
- Timing and bit order:
  - One bit per Clk.
  - Tx is registered, so a bit chosen in cycle N appears on Tx in cycle N+1.
  - All bytes are sent LSB-first.
- FSM: IDLE -> START_FLAG -> DATA -> FCS (skipped if FCS_EN=0) -> END_FLAG -> IDLE. ABORT -> IDLE.
- IDLE:
  - Tx=1 continuously (idle pattern).
  - Tx_Enable=1 with Tx_DataAvail=1 -> START_FLAG; Tx_AbortedTrans clears.
  - Tx_Enable with Tx_DataAvail=0 is ignored; empty frames are never sent.
- START_FLAG:
  - Sends 0,1,1,1,1,1,1,0.
  - The first 0 appears on Tx 2 cycles after the Tx_Enable cycle.
  - Tx_ValidFrame rises with the first flag bit.
  - On the last flag bit: pulse Tx_RdBuff, load the shift register, clear the ones counter, load CRC_INIT.
- DATA:
  - Shifts 8 data bits per byte.
  - Each data bit updates the FCS: CRC-16, reflected polynomial 0xA001, no final inversion. The FCS covers data bits only, before stuffing.
  - On the cycle the 8th bit is emitted: if Tx_DataAvail=1, pulse Tx_RdBuff and load the next byte (no gap); otherwise go to FCS or END_FLAG.
- Zero insertion:
  - Applies in DATA and FCS only.
  - After 5 consecutive 1s are emitted, the next Tx bit is a stuffed 0 and the ones counter clears.
  - A stuffed bit does not advance the bit counter and does not update the FCS.
  - The ones counter carries across byte boundaries and from DATA into FCS.
  - A 0 data bit clears the counter.
- FCS: sends the low FCS byte, then the high byte, each LSB-first, with stuffing applied.
- END_FLAG:
  - Sends 0x7E with no stuffing.
  - Tx_ValidFrame falls in the cycle after the last flag bit; Tx_Done pulses in that same cycle.
  - Then IDLE.
- Abort:
  - Tx_AbortFrame=1 in START_FLAG, DATA or FCS -> ABORT immediately. Any partially sent byte or stuffed bit is dropped.
  - Tx_AbortedTrans sets the following cycle and holds until the next accepted Tx_Enable.
  - No further Tx_RdBuff pulses; upstream flushes the buffer.
  - ABORT sends 0 followed by seven 1s. The first 0 appears on Tx 2 cycles after the Tx_AbortFrame cycle.
  - Tx_ValidFrame falls with the first abort bit. Then IDLE, with no Tx_Done.
  - Tx_AbortFrame is ignored in IDLE, END_FLAG and ABORT.
- Simultaneous events:
  - Tx_Enable and Tx_AbortFrame together in IDLE: the frame starts and the abort is ignored.
  - Abort in the same cycle as the 8th data bit with Tx_DataAvail=1: the abort wins and no Tx_RdBuff pulse is issued.
- Reset mid-frame: outputs immediately take their reset values. No closing flag and no abort pattern are sent.

Test Plan:
1. Idle: no stimulus for 32 cycles after reset -> Tx=1 throughout; Tx_ValidFrame=0; Tx_RdBuff never pulses.
2. Single byte 0x01, FCS_EN=1:
   - Tx bits: 01111110, 10000000, 10000011 (FCS low 0xC1), 00000011 (FCS high 0xC0), 01111110.
   - Exactly 1 Tx_RdBuff pulse; Tx_Done pulses once after the closing flag.
3. Zero insertion, bytes 0xFF,0xFF -> data field on Tx is 111110111 110111110 1111...; no run of six 1s between flags; FCS matches CRC-16/ARC of FF FF.
4. Back-to-back bytes 0x55,0xAA,0x0F held available -> 3 Tx_RdBuff pulses exactly 8 cycles apart; no idle bits between bytes.
5. Abort after 12 data bits:
   - Tx shows 0 then 1111111 starting 2 cycles after Tx_AbortFrame, then idle 1s.
   - Tx_AbortedTrans=1 until the next Tx_Enable; no Tx_Done; Tx_ValidFrame=0.
6. Async reset asserted mid-DATA -> Tx=1, Tx_ValidFrame=0 immediately; a new Tx_Enable afterwards produces a clean opening flag.
